// File: rtl/alu_sequencer_if.sv
// Request/response bus between the system side and alu_sequencer.
// master = bus-side requester, slave = the sequencer.
interface alu_sequencer_if #(
    parameter int SIZE = 4
) ();
    localparam int FULL_SIZE = 2 * SIZE;

    // Valid/ready: a transfer occurs on a rising edge where valid && ready are both 1.
    // Once valid is raised, the sender holds valid and its payload stable until that edge.
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_command;
    logic [SIZE-1:0]      req_a;
    logic [SIZE-1:0]      req_b;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [FULL_SIZE-1:0] rsp_result;
    logic                 rsp_overflow;
    logic                 rsp_error;

    modport master (
        output req_valid, req_command, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error
    );

    modport slave (
        input  req_valid, req_command, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error
    );
endinterface

// File: rtl/alu_sequencer.sv
// Front end for the combinational alu: takes one op per request handshake, drives the alu
// for two cycles, captures its result and returns it on the response port with counters.
module alu_sequencer #(
    parameter int SIZE  = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.slave        bus,
    output logic                  alu_enable,
    output logic [3:0]            alu_command,
    output logic [SIZE-1:0]       alu_a,
    output logic [SIZE-1:0]       alu_b,
    input  logic                  alu_overflow,
    input  logic [2*SIZE-1:0]     alu_result,
    output logic [CNT_W-1:0]      op_count,
    output logic [CNT_W-1:0]      ovf_count,
    output logic [1:0]            dbg_state
);
    localparam int FULL_SIZE = 2 * SIZE;
    localparam logic [3:0]       MAX_OPCODE = 4'd8;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t               state;
    logic [3:0]           cmd_q;
    logic [SIZE-1:0]      a_q;
    logic [SIZE-1:0]      b_q;
    logic                 enable_q;
    logic                 rsp_valid_q;
    logic [FULL_SIZE-1:0] rsp_result_q;
    logic                 rsp_overflow_q;
    logic                 rsp_error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            enable_q       <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_error_q    <= 1'b0;
            op_count       <= '0;
            ovf_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cmd_q <= bus.req_command;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        if (bus.req_command <= MAX_OPCODE) begin
                            state    <= DRIVE;
                            enable_q <= 1'b1;
                        end else begin
                            // Illegal opcode never reaches the alu; answer with an error at once.
                            state          <= RESPOND;
                            rsp_valid_q    <= 1'b1;
                            rsp_result_q   <= '0;
                            rsp_overflow_q <= 1'b0;
                            rsp_error_q    <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // Inputs have been steady for a whole cycle, so the alu output has settled.
                    rsp_result_q   <= alu_result;
                    rsp_overflow_q <= alu_overflow;
                    rsp_error_q    <= 1'b0;
                    rsp_valid_q    <= 1'b1;
                    enable_q       <= 1'b0;
                    state          <= RESPOND;
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                        if (op_count != CNT_MAX) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                        if (rsp_overflow_q && (ovf_count != CNT_MAX)) begin
                            ovf_count <= ovf_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst_n so ready stays low while reset is held.
    assign bus.req_ready    = rst_n && (state == IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_error    = rsp_error_q;

    assign alu_enable  = enable_q;
    assign alu_command = cmd_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed ops with hand-computed results, a queue-based scoreboard
// and a second lockstep instance with 2-bit counters for saturation.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer_if #(.SIZE(4)) bus ();
    alu_sequencer_if #(.SIZE(4)) bus2 ();

    logic       alu_enable, alu_overflow;
    logic [3:0] alu_command, alu_a, alu_b;
    logic [7:0] alu_result;
    logic [7:0] op_count, ovf_count;
    logic [1:0] dbg_state;

    logic       alu_enable2, alu_overflow2;
    logic [3:0] alu_command2, alu_a2, alu_b2;
    logic [7:0] alu_result2;
    logic [1:0] op_count2, ovf_count2;
    logic [1:0] dbg_state2;

    alu_sequencer #(.SIZE(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_enable(alu_enable), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
        .alu_overflow(alu_overflow), .alu_result(alu_result),
        .op_count(op_count), .ovf_count(ovf_count), .dbg_state(dbg_state)
    );

    alu_sequencer #(.SIZE(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .alu_enable(alu_enable2), .alu_command(alu_command2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_overflow(alu_overflow2), .alu_result(alu_result2),
        .op_count(op_count2), .ovf_count(ovf_count2), .dbg_state(dbg_state2)
    );

    assign bus2.req_valid   = bus.req_valid;
    assign bus2.req_command = bus.req_command;
    assign bus2.req_a       = bus.req_a;
    assign bus2.req_b       = bus.req_b;
    assign bus2.rsp_ready   = bus.rsp_ready;

    // Stand-in for the combinational alu; outputs zero while disabled.
    function automatic logic [8:0] alu_model(input logic en, input logic [3:0] cmd,
                                             input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [7:0] r;
        logic       o;
        s = '0;
        r = '0;
        o = 1'b0;
        if (en) begin
            case (cmd)
                4'd0: r = {4'b0, a & b};
                4'd1: r = {4'b0, a | b};
                4'd2: r = {4'b0, a ^ b};
                4'd3: r = {4'b0, ~a};
                4'd4: begin s = {1'b0, a} + {1'b0, b}; r = {3'b0, s}; o = s[4]; end
                4'd5: begin s = {1'b0, a} + {1'b0, b}; r = {4'b0, s[3:0]};
                            o = (a[3] == b[3]) && (s[3] != a[3]); end
                4'd6: begin s = {1'b0, a} - {1'b0, b}; r = {4'b0, s[3:0]}; o = s[4]; end
                4'd7: begin s = {1'b0, a} - {1'b0, b}; r = {4'b0, s[3:0]};
                            o = (a[3] != b[3]) && (s[3] != a[3]); end
                4'd8: begin r = {4'b0, a} * {4'b0, b}; o = (r[7:4] != 4'd0); end
                default: r = '0;
            endcase
        end
        return {o, r};
    endfunction

    assign {alu_overflow, alu_result}   = alu_model(alu_enable, alu_command, alu_a, alu_b);
    assign {alu_overflow2, alu_result2} = alu_model(alu_enable2, alu_command2, alu_a2, alu_b2);

    // Scoreboard: {latency[3:0], error, overflow, result[7:0]}
    logic [13:0] exp_q[$];
    int          t0_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          exp_op = 0;
    int          exp_ovf = 0;
    logic        seen = 1'b0;
    logic        en_forbid = 1'b0;
    logic [9:0]  snap = '0;
    logic [13:0] cur;
    int          t0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_op  = 0;
            exp_ovf = 0;
            seen    = 1'b0;
        end else begin
            if (en_forbid) chk("alu_enable_illegal", alu_enable, 1'b0);
            if (bus.rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    snap = {bus.rsp_error, bus.rsp_overflow, bus.rsp_result};
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        t0  = t0_q.pop_front();
                        chk("rsp_result", bus.rsp_result, cur[7:0]);
                        chk("rsp_overflow", bus.rsp_overflow, cur[8]);
                        chk("rsp_error", bus.rsp_error, cur[9]);
                        chk("latency", cyc - t0, cur[13:10]);
                    end
                end else begin
                    chk("rsp_hold", {bus.rsp_error, bus.rsp_overflow, bus.rsp_result}, snap);
                end
                chk("req_ready_busy", bus.req_ready, 1'b0);
                chk("op_count", op_count, sat(exp_op, 255));
                chk("ovf_count", ovf_count, sat(exp_ovf, 255));
                chk("op_count_sat", op_count2, sat(exp_op, 3));
                chk("ovf_count_sat", ovf_count2, sat(exp_ovf, 3));
                if (bus.rsp_ready) begin
                    seen = 1'b0;
                    exp_op++;
                    if (bus.rsp_overflow) exp_ovf++;
                end
            end
        end
    end

    task automatic send(input logic [3:0] cmd, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] res, input logic ovf, input logic err,
                        input logic [3:0] lat);
        int n = 0;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_command = cmd;
        bus.req_a       = a;
        bus.req_b       = b;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_accept_timeout", bus.req_ready, 1'b1);
        end else begin
            exp_q.push_back({lat, err, ovf, res});
            t0_q.push_back(cyc);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid   = 1'b0;
        bus.req_command = 4'd0;
        bus.req_a       = 4'd0;
        bus.req_b       = 4'd0;
        bus.rsp_ready   = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_alu_enable", alu_enable, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 8'h00);
        chk("rst_counts", {op_count, ovf_count}, 16'h0000);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1'b1);
        chk("post_rst_state", dbg_state, 2'd0);

        send(4'd0, 4'hA, 4'h5, 8'h00, 1'b0, 1'b0, 4'd3);
        send(4'd5, 4'h7, 4'h1, 8'h08, 1'b1, 1'b0, 4'd3);
        send(4'd8, 4'h7, 4'h8, 8'h38, 1'b1, 1'b0, 4'd3);
        send(4'd8, 4'h3, 4'h2, 8'h06, 1'b0, 1'b0, 4'd3);
        send(4'd1, 4'hA, 4'h5, 8'h0F, 1'b0, 1'b0, 4'd3);
        send(4'd2, 4'hF, 4'h3, 8'h0C, 1'b0, 1'b0, 4'd3);
        send(4'd4, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 4'd3);
        send(4'd6, 4'h3, 4'h5, 8'h0E, 1'b1, 1'b0, 4'd3);
        send(4'd7, 4'h8, 4'h1, 8'h07, 1'b1, 1'b0, 4'd3);
        wait_idle();

        // Backpressure: response held for 5 cycles
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        send(4'd3, 4'h5, 4'h0, 8'h0A, 1'b0, 1'b0, 4'd3);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) chk("rsp_valid_timeout", bus.rsp_valid, 1'b1);
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_idle();

        // Illegal opcode
        en_forbid = 1'b1;
        send(4'hC, 4'h3, 4'h3, 8'h00, 1'b0, 1'b1, 4'd1);
        wait_idle();
        repeat (2) @(negedge clk);
        en_forbid = 1'b0;

        chk("final_op_count", op_count, 8'd11);
        chk("final_ovf_count", ovf_count, 8'd5);
        chk("final_op_count_sat", op_count2, 2'd3);
        chk("final_ovf_count_sat", ovf_count2, 2'd3);

        // Reset while the alu is being driven
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_command = 4'd8;
        bus.req_a       = 4'h3;
        bus.req_b       = 4'h2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("drive_state", dbg_state, 2'd1);
        chk("drive_enable", alu_enable, 1'b1);
        chk("drive_alu_a", alu_a, 4'h3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", dbg_state, 2'd0);
        chk("mid_rst_enable", alu_enable, 1'b0);
        chk("mid_rst_counts", {op_count, ovf_count, op_count2, ovf_count2}, 20'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_req_ready", bus.req_ready, 1'b1);
        repeat (6) @(negedge clk);
        chk("mid_rst_no_rsp", bus.rsp_valid, 1'b0);
        chk("mid_rst_counts_after", {op_count, ovf_count}, 16'h0000);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
